barrel_shift_ctrl: RTL and testbench
====================================

BARREL_SHIFT_CTRL -- requirements
Module: barrel_shift_ctrl

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority (requester 0 wins).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N = 0, 1) presents a command.
REQ-005 reqN_ready  output  1  command from requester N accepted this cycle when high with reqN_valid.
REQ-006 reqN_data  input  8  operand to rotate.
REQ-007 reqN_amt  input  3  rotate amount (ignored for sweep commands).
REQ-008 reqN_lr  input  1  direction: 1 = rotate toward LSB (left-to-right), 0 = rotate toward MSB.
REQ-009 reqN_sweep  input  1  sweep command: emit all eight amounts 0..7.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  consumer accepts result when high with res_valid.
REQ-012 res_data / res_amt / res_id / res_last  output  8/3/1/1  rotated value, amount used, owning requester, final result of command.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 The block SHALL instantiate exactly one existing 8-bit barrel_shifter (ports data, amt, lr, out) and drive it only from internal capture registers.
REQ-015 FSM SHALL have states IDLE and RUN; reqN_ready SHALL be asserted only in IDLE, to at most one requester, and only when that requester's reqN_valid is high.
REQ-016 Arbitration in IDLE: single valid wins; both valid -> fixed priority gives requester 0; round-robin gives the requester not granted most recently, pointer updated only on an accepted command.
REQ-017 On acceptance (cycle N) the block SHALL capture data, lr, id, sweep and amt (0 if sweep) and enter RUN; res_valid SHALL rise in cycle N+1.
REQ-018 In RUN, res_data SHALL equal the shifter output for the captured operands; res_data, res_amt, res_id and res_last SHALL remain stable while res_valid and not res_ready.
REQ-019 res_last SHALL be 1 for non-sweep commands and for a sweep step with amt = 7, else 0.
REQ-020 On result handshake with res_last = 0, amt SHALL increment by 1 and res_valid SHALL stay high with the new result next cycle; with res_last = 1, FSM SHALL return to IDLE and res_valid SHALL be 0 next cycle.
REQ-021 No new command SHALL be accepted in the cycle a result handshake completes (minimum one IDLE cycle between commands).
REQ-022 Requester inputs changing while not granted SHALL have no effect; captured operands SHALL not change during RUN.

Reset
REQ-023 With reset high at a clock edge: FSM = IDLE, res_valid = 0, reqN_ready = 0, busy = 0, res_data/res_amt/res_id/res_last = 0, RR pointer favours requester 0.
REQ-024 Reset mid-command SHALL abandon the command with no further results; reset SHALL override any simultaneous handshake.

Configuration
REQ-025 Macro BSCTRL_SWEEP_EN defined: sweep commands behave per REQ-017..REQ-020.
REQ-026 Macro BSCTRL_SWEEP_EN undefined: reqN_sweep ports SHALL remain but be ignored; every command yields exactly one result with res_last = 1 using reqN_amt.

Verification
REQ-027 req0: data 0xF0, amt 3, lr 1 -> res_valid in next cycle, res_data 0x1E, res_id 0, res_last 1.
REQ-028 req1: data 0xF0, amt 3, lr 0, res_ready held low 5 cycles -> res_data 0x87 stable throughout, accepted on first res_ready cycle, busy then drops.
REQ-029 Both requesters valid continuously, RR_EN = 1 -> grants alternate 0,1,0,1; RR_EN = 0 -> requester 0 granted every time, requester 1 never.
REQ-030 BSCTRL_SWEEP_EN defined, sweep data 0x81, lr 0, res_ready high -> 8 consecutive results 0x81,0x03,0x06,0x0C,0x18,0x30,0x60,0xC0, res_amt 0..7, res_last only on 0xC0; undefined -> single result 0x81 at amt from reqN_amt 0.
REQ-031 Reset asserted during sweep step 4 -> next cycle res_valid 0, busy 0, no remaining sweep results; a new command after reset completes normally.

Source files
------------

// File: rtl/barrel_shift_ctrl_if.sv
// Bundle of the two requester command channels and the result channel
// of barrel_shift_ctrl, plus the busy flag and FSM state for observation.
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// when valid and ready are both high in that cycle; the producer holds its
// payload stable while valid is high and ready is low, and ready never
// depends on anything other than the current state and the valid inputs.
interface barrel_shift_ctrl_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req0_data;
    logic [2:0] req0_amt;
    logic       req0_lr;
    logic       req0_sweep;

    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] req1_data;
    logic [2:0] req1_amt;
    logic       req1_lr;
    logic       req1_sweep;

    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] res_amt;
    logic       res_id;
    logic       res_last;

    logic       busy;
    logic [0:0] dbg_state;

    modport master (
        output req0_valid, req0_data, req0_amt, req0_lr, req0_sweep,
        input  req0_ready,
        output req1_valid, req1_data, req1_amt, req1_lr, req1_sweep,
        input  req1_ready,
        input  res_valid, res_data, res_amt, res_id, res_last,
        output res_ready,
        input  busy, dbg_state
    );

    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_lr, req0_sweep,
        output req0_ready,
        input  req1_valid, req1_data, req1_amt, req1_lr, req1_sweep,
        output req1_ready,
        output res_valid, res_data, res_amt, res_id, res_last,
        input  res_ready,
        output busy, dbg_state
    );
endinterface

// File: rtl/barrel_shift_ctrl.sv
// barrel_shift_ctrl: two-requester front end for an 8-bit rotator.
// A command is accepted in IDLE, its operands are captured, and the rotated
// result(s) are presented on the result channel while in RUN.
// Optional feature macro: BSCTRL_SWEEP_EN -- when defined, a sweep command
// produces eight results for amounts 0..7; when undefined the sweep inputs
// are ignored and every command yields a single result.

// Plain 8-bit rotator: lr = 1 rotates toward the LSB, lr = 0 toward the MSB.
module barrel_shifter (
    input  logic [7:0] data,
    input  logic [2:0] amt,
    input  logic       lr,
    output logic [7:0] out
);
    logic [15:0] dbl;
    logic [15:0] sh;

    // Rotate by shifting a doubled copy of the operand.
    always_comb begin
        dbl = {data, data};
        sh  = '0;
        out = '0;
        if (lr) begin
            sh  = dbl >> amt;
            out = sh[7:0];
        end else begin
            sh  = dbl << amt;
            out = sh[15:8];
        end
    end
endmodule

module barrel_shift_ctrl #(
    parameter int RR_EN = 1
) (
    input  logic clk,
    input  logic reset,
    barrel_shift_ctrl_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

`ifdef BSCTRL_SWEEP_EN
    localparam logic SWEEP_EN = 1'b1;
`else
    localparam logic SWEEP_EN = 1'b0;
`endif

    logic [0:0] state;
    logic       rr_ptr;      // requester favoured on the next contended grant
    logic [7:0] cap_data;
    logic [2:0] cap_amt;
    logic       cap_lr;
    logic       cap_id;
    logic       cap_sweep;

    logic       grant_valid;
    logic       grant_id;
    logic [7:0] sel_data;
    logic [2:0] sel_amt;
    logic       sel_lr;
    logic       sel_sweep;
    logic [7:0] shift_out;
    logic       run;
    logic       last_step;

    assign run       = (state == RUN);
    assign last_step = ~cap_sweep | (cap_amt == 3'd7);

    // Pick at most one requester while idle; reset suppresses any grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state == IDLE && !reset) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = (RR_EN != 0) ? rr_ptr : 1'b0;
            end else if (bus.req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    // Route the granted requester's operands to the capture registers.
    always_comb begin
        sel_data  = grant_id ? bus.req1_data  : bus.req0_data;
        sel_amt   = grant_id ? bus.req1_amt   : bus.req0_amt;
        sel_lr    = grant_id ? bus.req1_lr    : bus.req0_lr;
        sel_sweep = (grant_id ? bus.req1_sweep : bus.req0_sweep) & SWEEP_EN;
    end

    // FSM, arbitration pointer and operand capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            cap_data  <= '0;
            cap_amt   <= '0;
            cap_lr    <= 1'b0;
            cap_id    <= 1'b0;
            cap_sweep <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state     <= RUN;
                        rr_ptr    <= ~grant_id;
                        cap_data  <= sel_data;
                        cap_lr    <= sel_lr;
                        cap_id    <= grant_id;
                        cap_sweep <= sel_sweep;
                        cap_amt   <= sel_sweep ? 3'd0 : sel_amt;
                    end
                end
                RUN: begin
                    if (bus.res_ready) begin
                        if (last_step) begin
                            state <= IDLE;
                        end else begin
                            cap_amt <= cap_amt + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    barrel_shifter u_shift (
        .data (cap_data),
        .amt  (cap_amt),
        .lr   (cap_lr),
        .out  (shift_out)
    );

    // Result channel is driven only from captured state, zero when idle.
    always_comb begin
        bus.req0_ready = grant_valid & ~grant_id;
        bus.req1_ready = grant_valid & grant_id;
        bus.res_valid  = run;
        bus.res_data   = run ? shift_out : 8'd0;
        bus.res_amt    = run ? cap_amt : 3'd0;
        bus.res_id     = run & cap_id;
        bus.res_last   = run & last_step;
        bus.busy       = run;
        bus.dbg_state  = state;
    end
endmodule

// File: tb/tb_barrel_shift_ctrl.sv
// Bench for barrel_shift_ctrl: one round-robin and one fixed-priority
// instance share the same stimulus; each is compared every cycle against a
// queue-based model of the results it owes, plus literal spot checks.
module tb_barrel_shift_ctrl;
    logic clk;
    logic rst;

    logic       v0, v1, lr0, lr1, sw0, sw1, rr;
    logic [7:0] d0, d1;
    logic [2:0] a0, a1;

    int checks = 0;
    int errors = 0;

    // model state: expected result words {last, id, amt, data}
    logic [12:0] exp_q0[$];
    logic [12:0] exp_q1[$];
    int          ptr[2];

    barrel_shift_ctrl_if if_rr ();
    barrel_shift_ctrl_if if_fp ();

    assign if_rr.req0_valid = v0;  assign if_fp.req0_valid = v0;
    assign if_rr.req0_data  = d0;  assign if_fp.req0_data  = d0;
    assign if_rr.req0_amt   = a0;  assign if_fp.req0_amt   = a0;
    assign if_rr.req0_lr    = lr0; assign if_fp.req0_lr    = lr0;
    assign if_rr.req0_sweep = sw0; assign if_fp.req0_sweep = sw0;
    assign if_rr.req1_valid = v1;  assign if_fp.req1_valid = v1;
    assign if_rr.req1_data  = d1;  assign if_fp.req1_data  = d1;
    assign if_rr.req1_amt   = a1;  assign if_fp.req1_amt   = a1;
    assign if_rr.req1_lr    = lr1; assign if_fp.req1_lr    = lr1;
    assign if_rr.req1_sweep = sw1; assign if_fp.req1_sweep = sw1;
    assign if_rr.res_ready  = rr;  assign if_fp.res_ready  = rr;

    barrel_shift_ctrl #(.RR_EN(1)) dut_rr (.clk(clk), .reset(rst), .bus(if_rr));
    barrel_shift_ctrl #(.RR_EN(0)) dut_fp (.clk(clk), .reset(rst), .bus(if_fp));

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rot(input logic [7:0] d, input int k, input logic lr);
        int v;
        int r;
        v = d;
        if (lr) r = (v >> k) | (v << (8 - k));
        else    r = (v << k) | (v >> (8 - k));
        return r[7:0];
    endfunction

    task automatic push_word(input int w, input logic [12:0] word);
        if (w == 0) exp_q0.push_back(word);
        else        exp_q1.push_back(word);
    endtask

    // Queue every result the accepted command is owed.
    task automatic push_cmd(input int w, input int id, input logic [7:0] d,
                            input logic [2:0] a, input logic lr, input logic sw);
        logic idb;
        idb = (id == 1);
`ifdef BSCTRL_SWEEP_EN
        if (sw) begin
            for (int k = 0; k < 8; k++)
                push_word(w, {(k == 7), idb, 3'(k), rot(d, k, lr)});
        end else begin
            push_word(w, {1'b1, idb, a, rot(d, a, lr)});
        end
`else
        if (sw || !sw) push_word(w, {1'b1, idb, a, rot(d, a, lr)});
`endif
    endtask

    task automatic check_dut(input int w, input logic rdy0, input logic rdy1,
                             input logic rv, input logic [7:0] rd, input logic [2:0] ra,
                             input logic rid, input logic rlast, input logic bsy);
        bit          has;
        logic [12:0] front;
        int          g;
        string       tag;
        tag   = (w == 0) ? "rr" : "fp";
        has   = (w == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
        front = '0;
        if (has) front = (w == 0) ? exp_q0[0] : exp_q1[0];
        g = -1;
        if (!rst && !has) begin
            if (v0 && v1) g = (w == 0) ? ptr[w] : 0;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        chk({tag, "_req0_ready"}, 32'(rdy0), 32'(g == 0));
        chk({tag, "_req1_ready"}, 32'(rdy1), 32'(g == 1));
        chk({tag, "_res_valid"}, 32'(rv), 32'(has));
        chk({tag, "_busy"}, 32'(bsy), 32'(has));
        if (has) chk({tag, "_result"}, 32'({rlast, rid, ra, rd}), 32'(front));
        if (rst) begin
            if (w == 0) exp_q0.delete(); else exp_q1.delete();
            ptr[w] = 0;
        end else begin
            if (has && rr) begin
                if (w == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
            end
            if (g == 0) begin push_cmd(w, 0, d0, a0, lr0, sw0); ptr[w] = 1; end
            if (g == 1) begin push_cmd(w, 1, d1, a1, lr1, sw1); ptr[w] = 0; end
        end
    endtask

    // per-cycle compare against the model
    initial begin
        ptr[0] = 0;
        ptr[1] = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check_dut(0, if_rr.req0_ready, if_rr.req1_ready, if_rr.res_valid, if_rr.res_data,
                      if_rr.res_amt, if_rr.res_id, if_rr.res_last, if_rr.busy);
            check_dut(1, if_fp.req0_ready, if_fp.req1_ready, if_fp.res_valid, if_fp.res_data,
                      if_fp.res_amt, if_fp.res_id, if_fp.res_last, if_fp.busy);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        v0 = 0; v1 = 0; sw0 = 0; sw1 = 0; lr0 = 0; lr1 = 0;
        d0 = 0; d1 = 0; a0 = 0; a1 = 0;
    endtask

    // driver and directed literal checks
    initial begin
        int g_rr[$];
        int g_fp0;
        int g_fp1;
        logic [7:0] sw_exp [8];
        idle_inputs();
        rr  = 1;
        rst = 1;
        repeat (3) step();
        @(negedge clk);
        chk("reset_res_valid", 32'(if_rr.res_valid), 0);
        chk("reset_res_last", 32'(if_rr.res_last), 0);
        step();
        rst = 0;
        step();

        // single command from requester 0, rotate toward LSB
        v0 = 1; d0 = 8'hF0; a0 = 3; lr0 = 1; sw0 = 0; rr = 1;
        step();
        v0 = 0;
        @(negedge clk);
        chk("lit_r0_valid", 32'(if_rr.res_valid), 1);
        chk("lit_r0_data", 32'(if_rr.res_data), 32'h1E);
        chk("lit_r0_id", 32'(if_rr.res_id), 0);
        chk("lit_r0_last", 32'(if_rr.res_last), 1);
        step();
        @(negedge clk);
        chk("lit_r0_busy_after", 32'(if_rr.busy), 0);
        step();

        // requester 1 with back-pressure
        v1 = 1; d1 = 8'hF0; a1 = 3; lr1 = 0; rr = 0;
        step();
        v1 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("lit_r1_hold_data", 32'(if_rr.res_data), 32'h87);
            chk("lit_r1_hold_id", 32'(if_rr.res_id), 1);
            step();
        end
        rr = 1;
        @(negedge clk);
        chk("lit_r1_accept_data", 32'(if_rr.res_data), 32'h87);
        step();
        @(negedge clk);
        chk("lit_r1_busy_after", 32'(if_rr.busy), 0);
        step();

        // both requesters valid continuously
        v0 = 1; v1 = 1; d0 = 8'h3C; d1 = 8'hA5; a0 = 1; a1 = 2; lr0 = 0; lr1 = 1;
        g_fp0 = 0; g_fp1 = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (if_rr.req0_ready) g_rr.push_back(0);
            if (if_rr.req1_ready) g_rr.push_back(1);
            if (if_fp.req0_ready) g_fp0++;
            if (if_fp.req1_ready) g_fp1++;
            step();
        end
        v0 = 0; v1 = 0;
        chk("rr_grant_count", 32'(g_rr.size()), 8);
        for (int i = 0; i < g_rr.size(); i++) chk("rr_grant_order", 32'(g_rr[i]), 32'(i % 2));
        chk("fp_grant0_count", 32'(g_fp0), 8);
        chk("fp_grant1_count", 32'(g_fp1), 0);
        step();
        step();

        // sweep command
        sw_exp = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0};
        v0 = 1; d0 = 8'h81; a0 = 0; lr0 = 0; sw0 = 1; rr = 1;
        step();
        v0 = 0; sw0 = 0;
`ifdef BSCTRL_SWEEP_EN
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("lit_sweep_data", 32'(if_rr.res_data), 32'(sw_exp[k]));
            chk("lit_sweep_amt", 32'(if_rr.res_amt), 32'(k));
            chk("lit_sweep_last", 32'(if_rr.res_last), 32'(k == 7));
            step();
        end
`else
        @(negedge clk);
        chk("lit_sweep_data", 32'(if_rr.res_data), 32'(sw_exp[0]));
        chk("lit_sweep_amt", 32'(if_rr.res_amt), 0);
        chk("lit_sweep_last", 32'(if_rr.res_last), 1);
        step();
`endif
        @(negedge clk);
        chk("lit_sweep_busy_after", 32'(if_rr.busy), 0);
        step();

        // reset in the middle of a command
`ifdef BSCTRL_SWEEP_EN
        v0 = 1; d0 = 8'h81; lr0 = 0; sw0 = 1; rr = 1;
        step();
        v0 = 0; sw0 = 0;
        repeat (4) step();
        @(negedge clk);
        chk("lit_mid_amt", 32'(if_rr.res_amt), 4);
`else
        v0 = 1; d0 = 8'h81; a0 = 4; lr0 = 0; rr = 0;
        step();
        v0 = 0;
        repeat (4) step();
`endif
        step();
        rst = 1;
        step();
        rst = 0;
        rr = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lit_post_reset_valid", 32'(if_rr.res_valid), 0);
            chk("lit_post_reset_busy", 32'(if_rr.busy), 0);
            step();
        end
        v1 = 1; d1 = 8'h5A; a1 = 1; lr1 = 1; sw1 = 0;
        step();
        v1 = 0;
        @(negedge clk);
        chk("lit_post_reset_data", 32'(if_rr.res_data), 32'h2D);
        chk("lit_post_reset_id", 32'(if_rr.res_id), 1);
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            v0  = ($urandom_range(0, 2) != 0);
            v1  = ($urandom_range(0, 2) != 0);
            d0  = 8'($urandom_range(0, 255));
            d1  = 8'($urandom_range(0, 255));
            a0  = 3'($urandom_range(0, 7));
            a1  = 3'($urandom_range(0, 7));
            lr0 = 1'($urandom_range(0, 1));
            lr1 = 1'($urandom_range(0, 1));
            sw0 = ($urandom_range(0, 3) == 0);
            sw1 = ($urandom_range(0, 3) == 0);
            rr  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        idle_inputs();
        rst = 0;
        rr  = 1;
        repeat (12) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
